// File: rtl/id_ex_hazard_reg_if.sv
// id_ex_hazard_reg_if
//   Bundles the ID-side instruction fields, the MEM/md-unit hazard inputs,
//   the flush request and the EX-stage register outputs of id_ex_hazard_reg.
//   master: the pipeline around the block (drives id_*, mem_*, md_busy, flush,
//           observes stall and ex_*).
//   slave:  id_ex_hazard_reg itself.
//   Parameter INSTR_W: width of the decoded-instruction code (0 is NOP).
interface id_ex_hazard_reg_if #(parameter int INSTR_W = 6);
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [31:0]        id_pc;
    logic [31:0]        id_rs_data;
    logic [31:0]        id_rt_data;
    logic [31:0]        id_imm32;
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic [1:0]         id_tuse_rs;
    logic [1:0]         id_tuse_rt;
    logic [4:0]         id_dst;
    logic [1:0]         id_tnew;
    logic [4:0]         mem_dst;
    logic [1:0]         mem_tnew;
    logic               md_busy;
    logic               flush;

    logic               stall;
    logic               ex_valid;
    logic [INSTR_W-1:0] ex_instr;
    logic [31:0]        ex_pc;
    logic [31:0]        ex_rs_data;
    logic [31:0]        ex_rt_data;
    logic [31:0]        ex_imm32;
    logic [4:0]         ex_dst;
    logic [1:0]         ex_tnew;
    logic [1:0]         ex_tnew_next;

    modport master (
        output id_valid, id_instr, id_pc, id_rs_data, id_rt_data, id_imm32,
               id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_dst, id_tnew,
               mem_dst, mem_tnew, md_busy, flush,
        input  stall, ex_valid, ex_instr, ex_pc, ex_rs_data, ex_rt_data,
               ex_imm32, ex_dst, ex_tnew, ex_tnew_next
    );

    modport slave (
        input  id_valid, id_instr, id_pc, id_rs_data, id_rt_data, id_imm32,
               id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_dst, id_tnew,
               mem_dst, mem_tnew, md_busy, flush,
        output stall, ex_valid, ex_instr, ex_pc, ex_rs_data, ex_rt_data,
               ex_imm32, ex_dst, ex_tnew, ex_tnew_next
    );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg
//   ID/EX pipeline register with integrated Tuse/Tnew and multiply/divide
//   hazard detection. Every cycle EX either captures the ID instruction or
//   receives a bubble; stall freezes PC and IF/ID while a hazard is present.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   bus (slave)   - id_* fields, mem_dst/mem_tnew, md_busy, flush in;
//                   stall and ex_* registered EX-stage fields out
//   stat_data_stalls, stat_md_stalls (only with HAZARD_STAT_EN) - 32-bit
//                   wrap-around counts of data-hazard and md-hazard cycles
// Configuration macro: HAZARD_STAT_EN enables the stall statistic counters.
module id_ex_hazard_reg #(
    parameter int INSTR_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    id_ex_hazard_reg_if.slave   bus
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0]         stat_data_stalls,
    output logic [31:0]         stat_md_stalls
`endif
);

    // Decoded-instruction codes of the multiply/divide class.
    localparam logic [INSTR_W-1:0] OP_MULT  = INSTR_W'(20);
    localparam logic [INSTR_W-1:0] OP_MULTU = INSTR_W'(21);
    localparam logic [INSTR_W-1:0] OP_DIV   = INSTR_W'(22);
    localparam logic [INSTR_W-1:0] OP_DIVU  = INSTR_W'(23);
    localparam logic [INSTR_W-1:0] OP_MADD  = INSTR_W'(24);
    localparam logic [INSTR_W-1:0] OP_MADDU = INSTR_W'(25);
    localparam logic [INSTR_W-1:0] OP_MSUB  = INSTR_W'(26);
    localparam logic [INSTR_W-1:0] OP_MSUBU = INSTR_W'(27);
    localparam logic [INSTR_W-1:0] OP_MFHI  = INSTR_W'(28);
    localparam logic [INSTR_W-1:0] OP_MFLO  = INSTR_W'(29);
    localparam logic [INSTR_W-1:0] OP_MTHI  = INSTR_W'(30);
    localparam logic [INSTR_W-1:0] OP_MTLO  = INSTR_W'(31);

    logic               valid_q,   valid_d;
    logic [INSTR_W-1:0] instr_q,   instr_d;
    logic [31:0]        pc_q,      pc_d;
    logic [31:0]        rs_data_q, rs_data_d;
    logic [31:0]        rt_data_q, rt_data_d;
    logic [31:0]        imm32_q,   imm32_d;
    logic [4:0]         dst_q,     dst_d;
    logic [1:0]         tnew_q,    tnew_d;

    logic is_md;
    logic hz_rs;
    logic hz_rt;
    logic hz_md;
    logic stall;

    always_comb begin
        is_md = 1'b0;
        case (bus.id_instr)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
            OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: is_md = 1'b1;
            default:                           is_md = 1'b0;
        endcase
    end

    // The MEM-stage term carries no valid qualifier: a bubble in MEM has
    // mem_dst = 0, which the register-0 guard already excludes.
    always_comb begin
        hz_rs = bus.id_valid && (bus.id_rs != 5'd0) && (bus.id_tuse_rs != 2'd3) &&
                ((valid_q && (bus.id_rs == dst_q) && (bus.id_tuse_rs < tnew_q)) ||
                 ((bus.id_rs == bus.mem_dst) && (bus.id_tuse_rs < bus.mem_tnew)));
        hz_rt = bus.id_valid && (bus.id_rt != 5'd0) && (bus.id_tuse_rt != 2'd3) &&
                ((valid_q && (bus.id_rt == dst_q) && (bus.id_tuse_rt < tnew_q)) ||
                 ((bus.id_rt == bus.mem_dst) && (bus.id_tuse_rt < bus.mem_tnew)));
        // MTHI/MTLO are included: the md unit drops writes while busy.
        hz_md = bus.id_valid && is_md && bus.md_busy;
        stall = hz_rs || hz_rt || hz_md;
    end

    // EX never holds: it takes either the ID instruction or a bubble.
    // An invalid ID slot is treated as a bubble so no stale fields leak.
    always_comb begin
        valid_d   = 1'b0;
        instr_d   = '0;
        pc_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm32_d   = '0;
        dst_d     = '0;
        tnew_d    = '0;
        if (!bus.flush && !stall && bus.id_valid) begin
            valid_d   = 1'b1;
            instr_d   = bus.id_instr;
            pc_d      = bus.id_pc;
            rs_data_d = bus.id_rs_data;
            rt_data_d = bus.id_rt_data;
            imm32_d   = bus.id_imm32;
            dst_d     = bus.id_dst;
            tnew_d    = bus.id_tnew;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm32_q   <= '0;
            dst_q     <= '0;
            tnew_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm32_q   <= imm32_d;
            dst_q     <= dst_d;
            tnew_q    <= tnew_d;
        end
    end

`ifdef HAZARD_STAT_EN
    logic [31:0] stat_data_q, stat_data_d;
    logic [31:0] stat_md_q,   stat_md_d;

    // A cycle carrying both hazard kinds bumps both counters.
    always_comb begin
        stat_data_d = stat_data_q;
        stat_md_d   = stat_md_q;
        if (hz_rs || hz_rt) stat_data_d = stat_data_q + 32'd1;
        if (hz_md)          stat_md_d   = stat_md_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_data_q <= '0;
            stat_md_q   <= '0;
        end else begin
            stat_data_q <= stat_data_d;
            stat_md_q   <= stat_md_d;
        end
    end

    assign stat_data_stalls = stat_data_q;
    assign stat_md_stalls   = stat_md_q;
`endif

    assign bus.stall        = stall;
    assign bus.ex_valid     = valid_q;
    assign bus.ex_instr     = instr_q;
    assign bus.ex_pc        = pc_q;
    assign bus.ex_rs_data   = rs_data_q;
    assign bus.ex_rt_data   = rt_data_q;
    assign bus.ex_imm32     = imm32_q;
    assign bus.ex_dst       = dst_q;
    assign bus.ex_tnew      = tnew_q;
    assign bus.ex_tnew_next = (tnew_q == 2'd0) ? 2'd0 : (tnew_q - 2'd1);

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb_id_ex_hazard_reg
//   Directed bench for id_ex_hazard_reg: data capture, load-use stall, rt
//   hazard, register-0 and invalid-slot cases, DIV/MFLO md stall, MTHI while
//   busy, flush, and reset during a stall. With HAZARD_STAT_EN the stall
//   counters are checked as well.
module tb_id_ex_hazard_reg;

    localparam logic [5:0] NOP  = 6'd0;
    localparam logic [5:0] ADDU = 6'd1;
    localparam logic [5:0] LW   = 6'd10;
    localparam logic [5:0] DIV  = 6'd22;
    localparam logic [5:0] MFLO = 6'd29;
    localparam logic [5:0] MTHI = 6'd30;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    id_ex_hazard_reg_if #(.INSTR_W(6)) bus ();

`ifdef HAZARD_STAT_EN
    logic [31:0] stat_data_stalls;
    logic [31:0] stat_md_stalls;
`endif

    id_ex_hazard_reg #(.INSTR_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef HAZARD_STAT_EN
        ,
        .stat_data_stalls (stat_data_stalls),
        .stat_md_stalls   (stat_md_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [5:0] instr,
                                 input logic [31:0] pc, input logic [31:0] rs_data,
                                 input logic [31:0] rt_data, input logic [31:0] imm,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                                 input logic [4:0] dst, input logic [1:0] tnew);
        bus.id_valid   = valid;
        bus.id_instr   = instr;
        bus.id_pc      = pc;
        bus.id_rs_data = rs_data;
        bus.id_rt_data = rt_data;
        bus.id_imm32   = imm;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_tuse_rs = tuse_rs;
        bus.id_tuse_rt = tuse_rt;
        bus.id_dst     = dst;
        bus.id_tnew    = tnew;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.mem_dst   = 5'd0;
        bus.mem_tnew  = 2'd0;
        bus.md_busy   = 1'b0;
        bus.flush     = 1'b0;
        applyStimulus(1'b0, NOP, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        checkOutput("rst_ex_valid", bus.ex_valid, 0);
        checkOutput("rst_ex_instr", bus.ex_instr, 0);
        checkOutput("rst_ex_pc", bus.ex_pc, 0);
        checkOutput("rst_ex_dst", bus.ex_dst, 0);
        checkOutput("rst_stall", bus.stall, 0);

        // Data capture
        applyStimulus(1'b1, ADDU, 32'h3000, 32'd5, 32'd7, 32'h10, 5'd2, 5'd3, 2'd1, 2'd1, 5'd4, 2'd1);
        checkOutput("cap_stall", bus.stall, 0);
        tick();
        checkOutput("cap_ex_pc", bus.ex_pc, 32'h3000);
        checkOutput("cap_ex_rs_data", bus.ex_rs_data, 5);
        checkOutput("cap_ex_rt_data", bus.ex_rt_data, 7);
        checkOutput("cap_ex_imm32", bus.ex_imm32, 32'h10);
        checkOutput("cap_ex_valid", bus.ex_valid, 1);
        checkOutput("cap_ex_instr", bus.ex_instr, ADDU);
        checkOutput("cap_ex_dst", bus.ex_dst, 4);
        checkOutput("cap_ex_tnew_next", bus.ex_tnew_next, 0);

        // Load-use: LW $1 enters EX
        applyStimulus(1'b1, LW, 32'h3004, 32'd2, 32'd0, 32'h8, 5'd2, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2);
        checkOutput("lw_stall", bus.stall, 0);
        tick();
        checkOutput("lw_ex_tnew", bus.ex_tnew, 2);
        checkOutput("lw_ex_tnew_next", bus.ex_tnew_next, 1);
        bus.mem_dst  = 5'd4;
        bus.mem_tnew = 2'd0;
        applyStimulus(1'b1, ADDU, 32'h3008, 32'd11, 32'd12, 32'h0, 5'd1, 5'd5, 2'd1, 2'd1, 5'd6, 2'd1);
        checkOutput("lu_stall", bus.stall, 1);
        tick();
        checkOutput("lu_bubble_valid", bus.ex_valid, 0);
        checkOutput("lu_bubble_instr", bus.ex_instr, NOP);
        checkOutput("lu_bubble_dst", bus.ex_dst, 0);
        checkOutput("lu_bubble_pc", bus.ex_pc, 0);
        bus.mem_dst  = 5'd1;
        bus.mem_tnew = 2'd1;
        #1;
        checkOutput("lu_released", bus.stall, 0);
        tick();
        checkOutput("lu_ex_instr", bus.ex_instr, ADDU);
        checkOutput("lu_ex_pc", bus.ex_pc, 32'h3008);
        checkOutput("lu_ex_valid", bus.ex_valid, 1);

        // rt hazard against EX (ADDU $6, tnew 1), then rt not read
        applyStimulus(1'b1, ADDU, 32'h300c, 32'd0, 32'd0, 32'h0, 5'd0, 5'd6, 2'd3, 2'd0, 5'd7, 2'd1);
        checkOutput("rt_ex_stall", bus.stall, 1);
        applyStimulus(1'b1, ADDU, 32'h300c, 32'd0, 32'd0, 32'h0, 5'd0, 5'd6, 2'd3, 2'd3, 5'd7, 2'd1);
        checkOutput("rt_unread_stall", bus.stall, 0);
        // rt hazard against MEM
        bus.mem_dst  = 5'd9;
        bus.mem_tnew = 2'd2;
        applyStimulus(1'b1, ADDU, 32'h300c, 32'd0, 32'd0, 32'h0, 5'd0, 5'd9, 2'd3, 2'd1, 5'd7, 2'd1);
        checkOutput("rt_mem_stall", bus.stall, 1);

        // Register 0 never stalls, even with mem_dst = 0 and a large tnew
        bus.mem_dst  = 5'd0;
        bus.mem_tnew = 2'd3;
        applyStimulus(1'b1, ADDU, 32'h3010, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 2'd0, 2'd0, 5'd8, 2'd1);
        checkOutput("zero_reg_stall", bus.stall, 0);
        bus.mem_tnew = 2'd0;

        // Invalid slot with md-class code while busy
        bus.md_busy = 1'b1;
        applyStimulus(1'b0, MFLO, 32'h3014, 32'd3, 32'd4, 32'h0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1);
        checkOutput("inv_stall", bus.stall, 0);
        tick();
        checkOutput("inv_ex_valid", bus.ex_valid, 0);
        checkOutput("inv_ex_instr", bus.ex_instr, NOP);

        // MTHI while busy stalls, ADDU while busy does not
        applyStimulus(1'b1, MTHI, 32'h3018, 32'd1, 32'd0, 32'h0, 5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0);
        checkOutput("mthi_busy_stall", bus.stall, 1);
        applyStimulus(1'b1, ADDU, 32'h301c, 32'd1, 32'd2, 32'h0, 5'd2, 5'd3, 2'd1, 2'd1, 5'd4, 2'd1);
        checkOutput("addu_busy_stall", bus.stall, 0);

        // DIV then MFLO, counters start from zero
        bus.md_busy = 1'b0;
        doReset();
        applyStimulus(1'b1, DIV, 32'h3020, 32'd100, 32'd7, 32'h0, 5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0);
        checkOutput("div_stall", bus.stall, 0);
        tick();
        checkOutput("div_ex_instr", bus.ex_instr, DIV);
        bus.md_busy = 1'b1;
        applyStimulus(1'b1, MFLO, 32'h3024, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1);
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("md_stall_%0d", i), bus.stall, 1);
            tick();
            checkOutput($sformatf("md_bubble_%0d", i), bus.ex_instr, NOP);
        end
        bus.md_busy = 1'b0;
        #1;
        checkOutput("md_release", bus.stall, 0);
        tick();
        checkOutput("mflo_ex_instr", bus.ex_instr, MFLO);
        checkOutput("mflo_ex_dst", bus.ex_dst, 10);
`ifdef HAZARD_STAT_EN
        checkOutput("stat_md_11", stat_md_stalls, 11);
        checkOutput("stat_data_0", stat_data_stalls, 0);
`endif

        // Flush together with an md stall: bubble, stall still asserted
        bus.md_busy = 1'b1;
        bus.flush   = 1'b1;
        applyStimulus(1'b1, MTHI, 32'h3028, 32'd5, 32'd0, 32'h0, 5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0);
        checkOutput("flush_stall_stall", bus.stall, 1);
        tick();
        checkOutput("flush_stall_valid", bus.ex_valid, 0);
        // Flush alone with a valid ADDU
        bus.md_busy = 1'b0;
        applyStimulus(1'b1, ADDU, 32'h302c, 32'd5, 32'd6, 32'h0, 5'd2, 5'd3, 2'd1, 2'd1, 5'd4, 2'd1);
        checkOutput("flush_stall", bus.stall, 0);
        tick();
        checkOutput("flush_ex_valid", bus.ex_valid, 0);
        checkOutput("flush_ex_instr", bus.ex_instr, NOP);
        checkOutput("flush_ex_pc", bus.ex_pc, 0);
        bus.flush = 1'b0;

        // Capture something, then reset while a stall is in progress
        tick();
        checkOutput("pre_rst_ex_pc", bus.ex_pc, 32'h302c);
        bus.md_busy = 1'b1;
        applyStimulus(1'b1, MTHI, 32'h3030, 32'd5, 32'd0, 32'h0, 5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0);
        checkOutput("mid_stall", bus.stall, 1);
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_valid", bus.ex_valid, 0);
        checkOutput("mid_rst_instr", bus.ex_instr, NOP);
        checkOutput("mid_rst_pc", bus.ex_pc, 0);
        checkOutput("mid_rst_rs_data", bus.ex_rs_data, 0);
        checkOutput("mid_rst_tnew", bus.ex_tnew, 0);
`ifdef HAZARD_STAT_EN
        checkOutput("mid_rst_stat_md", stat_md_stalls, 0);
        checkOutput("mid_rst_stat_data", stat_data_stalls, 0);
`endif
        reset = 1'b0;
        #1;
        checkOutput("post_rst_stall", bus.stall, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
